// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner: hold-FSM state
// encoding and width helpers for the counters.
package button_pkg;

  // Hold-FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } hold_state_t;

  // Counter width able to hold 0..value-1; never narrower than one bit.
  function automatic int clog2_safe(input int value);
    if (value <= 2) begin
      return 1;
    end
    return $clog2(value);
  endfunction

  // Larger of two integers, used to size the shared hold/repeat counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle of raw button inputs and conditioned button outputs.
// The board side (or bench) uses master; the conditioner uses slave.
interface button_conditioner_if #(
  parameter int N_BTN = 2
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_press;
  logic [N_BTN-1:0] repeat_pulse;

  modport master (
    output btn_raw,
    input  level,
    input  press,
    input  release_pulse,
    input  long_press,
    input  repeat_pulse
  );

  modport slave (
    input  btn_raw,
    output level,
    output press,
    output release_pulse,
    output long_press,
    output repeat_pulse
  );

endinterface

// File: rtl/button_conditioner_one.sv
// Single-button conditioner: 2-FF synchronizer, counter debounce,
// press/release pulses and long-press detection with auto-repeat.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | button released, waiting for a debounced press pulse
//   HELD   | pressed, counting toward the long-press threshold
//   REPEAT | long press reported, emitting periodic repeat pulses
module button_conditioner_one
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int REPEAT_CYCLES   = 2400000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int DW = clog2_safe(DEBOUNCE_CYCLES);
  localparam int HW = clog2_safe(max_int(LONG_CYCLES, REPEAT_CYCLES));

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  logic          s0;
  logic          s1;
  logic [DW-1:0] cnt;
  hold_state_t   state;
  logic [HW-1:0] hcnt;

  logic db_done;
  logic fall_now;

  // The debounce terminal count is reached this cycle.
  assign db_done  = (s1 != level) && (cnt == DB_LAST);
  // A release is being accepted this cycle; the hold FSM must see it now
  // so that a coinciding long/repeat terminal count is suppressed.
  assign fall_now = db_done && level;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= btn_raw;
      s1 <= s0;
    end
  end

  // Debounce: accept a new level after it has persisted for the full count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      if (s1 == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level         <= s1;
        cnt           <= '0;
        press         <= s1;
        release_pulse <= ~s1;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

  // Hold FSM: long press after the hold threshold, then periodic repeats.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      hcnt         <= '0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            state <= HELD;
            hcnt  <= HW'(1);
          end
        end
        HELD: begin
          if (!level || fall_now) begin
            state <= IDLE;
            hcnt  <= '0;
          end else if (hcnt == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= REPEAT;
            hcnt       <= '0;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        REPEAT: begin
          if (!level || fall_now) begin
            state <= IDLE;
            hcnt  <= '0;
          end else if (hcnt == REP_LAST) begin
            repeat_pulse <= 1'b1;
            hcnt         <= '0;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: begin
          state <= IDLE;
          hcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN independent raw push-buttons; one conditioner per button,
// no interaction between buttons.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int REPEAT_CYCLES   = 2400000
) (
  input  logic                 CLK,
  input  logic                 RST,
  button_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] level_v;
  logic [N_BTN-1:0] press_v;
  logic [N_BTN-1:0] release_v;
  logic [N_BTN-1:0] long_v;
  logic [N_BTN-1:0] repeat_v;

  // One fully independent conditioner per button.
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_conditioner_one #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_one (
      .CLK           (CLK),
      .RST           (RST),
      .btn_raw       (bus.btn_raw[i]),
      .level         (level_v[i]),
      .press         (press_v[i]),
      .release_pulse (release_v[i]),
      .long_press    (long_v[i]),
      .repeat_pulse  (repeat_v[i])
    );
  end

  assign bus.level         = level_v;
  assign bus.press         = press_v;
  assign bus.release_pulse = release_v;
  assign bus.long_press    = long_v;
  assign bus.repeat_pulse  = repeat_v;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw board push-buttons (BTN[1:0] on the 12 MHz Cmod A7 top) before any user logic consumes them.
- Per button:
  - 2-FF synchronizer
  - counter-based debounce
  - one-cycle press and release pulses
  - long-press detection with auto-repeat
- Instantiated directly behind the top-level BTN pins.
- Outputs drive LED/RGB demo logic and menu-style controls.

Parameters:
- N_BTN, 2, number of independent buttons
- DEBOUNCE_CYCLES, 120000, cycles the synchronized input must differ from the debounced level before it is accepted (10 ms at 12 MHz); legal range 2 or more
- LONG_CYCLES, 12000000, cycles of continuous debounced hold, measured from the press pulse, before long_press fires (1 s); must be greater than DEBOUNCE_CYCLES
- REPEAT_CYCLES, 2400000, period of repeat pulses after long_press (200 ms); legal range 2 or more

Ports:
- CLK  in  1  system clock, 12 MHz
- RST  in  1  reset; synchronous and active-high
- btn_raw  in  N_BTN  asynchronous raw button inputs, active-high
- level  out  N_BTN  debounced button level
- press  out  N_BTN  one-cycle pulse on debounced 0->1
- release  out  N_BTN  one-cycle pulse on debounced 1->0
- long_press  out  N_BTN  one-cycle pulse when hold reaches LONG_CYCLES
- repeat  out  N_BTN  one-cycle pulse every REPEAT_CYCLES after long_press while held

Behaviour:
- Buttons are fully independent; no cross-button interaction, arbitration or priority.
- Reset, at the RST edge:
  - Synchronizer flops, level, debounce counter and hold counter go to 0.
  - FSM goes to IDLE.
  - All pulse outputs go to 0.
  - No pulse is emitted during the reset cycle or the cycle after it.
- Synchronizer: s0 <= btn_raw; s1 <= s0. Only s1 is used downstream.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES):
  - If s1 == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= s1, cnt <= 0, and press or release is registered for exactly one cycle.
  - Else: cnt <= cnt+1.
- Latency: level and press rise DEBOUNCE_CYCLES+2 rising edges after the edge that first samples btn_raw high (that sampling edge counts as edge 1). Release has the same latency.
- Glitch rejection: any s1 excursion shorter than DEBOUNCE_CYCLES cycles resets the counter and produces no output change.
- Hold FSM, counter hcnt of width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)):
  - IDLE:
    - On the press pulse: go to HELD, hcnt <= 1.
  - HELD:
    - If level == 0: go to IDLE.
    - Else if hcnt == LONG_CYCLES-1: long_press pulse, go to REPEAT, hcnt <= 0.
    - Else: hcnt++.
    - Result: long_press is asserted exactly LONG_CYCLES cycles after the press pulse.
  - REPEAT:
    - If level == 0: go to IDLE.
    - Else if hcnt == REPEAT_CYCLES-1: repeat pulse, hcnt <= 0.
    - Else: hcnt++.
    - Result: the first repeat comes REPEAT_CYCLES cycles after long_press, then one every REPEAT_CYCLES.
- Release before LONG_CYCLES: no long_press and no repeat; the pending count is discarded.
- Release coinciding with a long or repeat terminal count: release wins, and no long_press or repeat is emitted in that cycle.
- press and release are never asserted in the same cycle for the same button.
- Reset mid-hold: all state clears. If the button is still held, a fresh press comes DEBOUNCE_CYCLES+2 edges after reset deasserts (the held button counts as a new press).
- Counters saturate nowhere and wrap nowhere; every counter is explicitly cleared at its terminal value.

Decomposition:
- Shared package or include button_pkg holds:
  - FSM state localparams: IDLE=2'd0, HELD=2'd1, REPEAT=2'd2
  - a clog2-safe width helper function
- Natural sub-module: button_conditioner_one, a single-button sync, debounce and FSM with the same parameters and scalar ports.
- The top generates N_BTN instances of button_conditioner_one.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5.
- Clean press: btn_raw[0] goes 0->1 and is sampled at edge E -> level[0] and a press[0] pulse appear after edge E+5. btn_raw[1] has no activity, and all its outputs stay 0.
- Bounce: btn_raw[0] toggles 1,0,1,0 on successive cycles, then holds 1 -> exactly one press[0] pulse, 6 edges after the final rising sample. No release pulse.
- Glitch: a 3-cycle high pulse on btn_raw[1] -> level[1], press[1] and release[1] never assert.
- Long hold: hold btn_raw[0] for 40 cycles after press at cycle P:
  - long_press[0] at P+20
  - repeat[0] at P+25, P+30 and P+35
  - then release[0] 6 edges after btn_raw drops
- Short hold: release btn_raw[0] so that level drops at P+12 -> release pulse only; no long_press and no repeat.
- Reset mid-hold: assert RST for 1 cycle at P+22 while btn_raw is held -> all outputs go 0 on the next cycle; a new press comes 6 edges after RST deasserts, and long_press 20 cycles after that press.
